fir_out_quant: RTL

Output requantizer for the FIR datapath. It accepts full-precision FIR results (`OUT_SIZE` bits, 21 at default package settings), then rounds, shifts and saturates them back to a `BIT_PREC`-bit signed sample for the output wave stream. It sits directly downstream of the FIR core and uses valid/ready on both sides, buffering through a 2-entry skid stage so back-pressure never creates a combinational path to the FIR. It also keeps a sticky-saturating count of clipped samples for debug.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_skid2.sv | 92 +++++++++
 rtl/fir_out_quant.sv | 86 ++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared FIR datapath constants and types, including the output-requantizer
// sample type and the skid-buffer occupancy encoding.
package fir_pkg;

   localparam int BIT_PREC = 8;
   localparam int OUT_SIZE = 21;

   typedef logic signed [BIT_PREC-1:0] qsample_t;

   localparam int QSHIFT = BIT_PREC - 1;
   localparam int QMAX   = 2**(BIT_PREC-1) - 1;
   localparam int QMIN   = -(2**(BIT_PREC-1));

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/fir_skid2.sv
// Generic 2-entry valid/ready buffer; in_ready and out_valid are registered so
// downstream back-pressure never reaches the producer combinationally.
module fir_skid2
   import fir_pkg::*;
#(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   occ_e         occ_r;
   occ_e         occ_nxt_s;
   logic [W-1:0] head_r;
   logic [W-1:0] tail_r;
   logic [W-1:0] head_nxt_s;
   logic [W-1:0] tail_nxt_s;
   logic         in_ready_r;
   logic         out_valid_r;
   logic         push_s;
   logic         pop_s;

   assign push_s    = in_valid && in_ready_r;
   assign pop_s     = out_valid_r && out_ready;
   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = head_r;

   // Next occupancy and entry contents; a simultaneous push/pop at one entry replaces the head.
   always_comb begin
      occ_nxt_s  = occ_r;
      head_nxt_s = head_r;
      tail_nxt_s = tail_r;
      case (occ_r)
         OCC_EMPTY: begin
            if (push_s) begin
               head_nxt_s = in_data;
               occ_nxt_s  = OCC_ONE;
            end else begin
               occ_nxt_s  = OCC_EMPTY;
            end
         end
         OCC_ONE: begin
            if (push_s && pop_s) begin
               head_nxt_s = in_data;
            end else if (push_s) begin
               tail_nxt_s = in_data;
               occ_nxt_s  = OCC_TWO;
            end else if (pop_s) begin
               occ_nxt_s  = OCC_EMPTY;
            end else begin
               occ_nxt_s  = OCC_ONE;
            end
         end
         OCC_TWO: begin
            if (pop_s) begin
               head_nxt_s = tail_r;
               occ_nxt_s  = OCC_ONE;
            end else begin
               occ_nxt_s  = OCC_TWO;
            end
         end
         default: begin
            occ_nxt_s = OCC_EMPTY;
         end
      endcase
   end

   // State, storage and registered handshake flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_r       <= OCC_EMPTY;
         head_r      <= {W{1'b0}};
         tail_r      <= {W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         occ_r       <= occ_nxt_s;
         head_r      <= head_nxt_s;
         tail_r      <= tail_nxt_s;
         in_ready_r  <= (occ_nxt_s != OCC_TWO);
         out_valid_r <= (occ_nxt_s != OCC_EMPTY);
      end
   end

endmodule

// File: rtl/fir_out_quant.sv
// FIR output requantizer: round-half-up, arithmetic shift, saturate to OUT_W
// bits, buffered through a 2-entry skid with a sticky clipped-sample counter.
module fir_out_quant
   import fir_pkg::*;
#(
   parameter int IN_W  = OUT_SIZE,
   parameter int OUT_W = BIT_PREC,
   parameter int SHIFT = QSHIFT,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [IN_W-1:0]  in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_sat,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        sat_count,
   input  logic                    clr_count
);

   localparam logic signed [IN_W:0] RND_C = {{IN_W{1'b0}}, 1'b1} <<< (SHIFT - 1);
   localparam logic signed [IN_W:0] Q_HI  = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W:0] Q_LO  = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0]     CNT_MAX = {CNT_W{1'b1}};

   logic signed [IN_W:0] rnd_s;
   logic signed [IN_W:0] q_s;
   logic [OUT_W-1:0]     qdata_s;
   logic                 qsat_s;
   logic                 in_ready_s;
   logic                 push_s;
   logic [OUT_W:0]       head_s;
   logic [CNT_W-1:0]     cnt_r;

   // Round, floor-shift and clip the incoming FIR result (one extra bit avoids overflow).
   always_comb begin
      rnd_s = $signed({in_data[IN_W-1], in_data}) + RND_C;
      q_s   = rnd_s >>> SHIFT;
      if (q_s > Q_HI) begin
         qdata_s = Q_HI[OUT_W-1:0];
         qsat_s  = 1'b1;
      end else if (q_s < Q_LO) begin
         qdata_s = Q_LO[OUT_W-1:0];
         qsat_s  = 1'b1;
      end else begin
         qdata_s = q_s[OUT_W-1:0];
         qsat_s  = 1'b0;
      end
   end

   fir_skid2 #(
      .W (OUT_W + 1)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   ({qsat_s, qdata_s}),
      .in_valid  (in_valid),
      .in_ready  (in_ready_s),
      .out_data  (head_s),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign push_s    = in_valid && in_ready_s;
   assign in_ready  = in_ready_s;
   assign out_sat   = head_s[OUT_W];
   assign out_data  = head_s[OUT_W-1:0];
   assign sat_count = cnt_r;

   // Sticky clipped-sample counter; clear takes priority over a coincident increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clr_count) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (push_s && qsat_s && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule
